// File: rtl/ahb_mem_router.sv
// ahb_mem_router: three-master AHB-lite crossbar onto instruction RAM, data RAM and register file
module ahb_mem_router #(
    parameter int RAM_AW        = 13,
    parameter int REG_AW        = 4,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SPI_change,
    output logic              run_mode,
    input  logic [31:0]       spi_haddr,
    input  logic [31:0]       spi_hwdata,
    input  logic              spi_hwrite,
    input  logic [2:0]        spi_hsize,
    input  logic [1:0]        spi_htrans,
    input  logic [2:0]        spi_hburst,
    input  logic [3:0]        spi_hprot,
    input  logic              spi_hmastlock,
    output logic [31:0]       spi_hrdata,
    output logic              spi_hready,
    output logic              spi_hresp,
    input  logic [31:0]       imem_haddr,
    input  logic [31:0]       imem_hwdata,
    input  logic              imem_hwrite,
    input  logic [2:0]        imem_hsize,
    input  logic [1:0]        imem_htrans,
    input  logic [2:0]        imem_hburst,
    input  logic [3:0]        imem_hprot,
    input  logic              imem_hmastlock,
    output logic [31:0]       imem_hrdata,
    output logic              imem_hready,
    output logic              imem_hresp,
    input  logic [31:0]       dmem_haddr,
    input  logic [31:0]       dmem_hwdata,
    input  logic              dmem_hwrite,
    input  logic [2:0]        dmem_hsize,
    input  logic [1:0]        dmem_htrans,
    input  logic [2:0]        dmem_hburst,
    input  logic [3:0]        dmem_hprot,
    input  logic              dmem_hmastlock,
    output logic [31:0]       dmem_hrdata,
    output logic              dmem_hready,
    output logic              dmem_hresp,
    input  logic [31:0]       inst_read,
    output logic [31:0]       inst_write,
    output logic [RAM_AW-1:0] inst_addr,
    output logic [3:0]        inst_wben,
    output logic              inst_rwn,
    output logic              inst_en,
    input  logic [31:0]       data_read,
    output logic [31:0]       data_write,
    output logic [RAM_AW-1:0] data_addr,
    output logic [3:0]        data_wben,
    output logic              data_rwn,
    output logic              data_en,
    input  logic [31:0]       reg_read,
    output logic [31:0]       reg_write,
    output logic [REG_AW-1:0] reg_addr,
    output logic [3:0]        reg_wben,
    output logic              reg_rwn,
    output logic              reg_en
);
    localparam int CW = RAM_AW + 4;
    typedef enum logic [2:0] {IDLE, WPEND, RISSUE, RDATA, ERR1, ERR2} state_t;
    logic [2:0][31:0]       haddr, hwdata, hrdata, trd, twrite;
    logic [2:0][2:0]        hsize;
    logic [2:0]             hwrite, htr, hready, hresp, req, gnt, cwr, idle, ten, trwn;
    logic [2:0][1:0]        tgt, sel;
    logic [2:0][3:0]        be, twben;
    logic [2:0][RAM_AW-1:0] widx, taddr;
    logic                   chg;
    logic                   unused;
    assign haddr  = {dmem_haddr, imem_haddr, spi_haddr};
    assign hwdata = {dmem_hwdata, imem_hwdata, spi_hwdata};
    assign hsize  = {dmem_hsize, imem_hsize, spi_hsize};
    assign hwrite = {dmem_hwrite, imem_hwrite, spi_hwrite};
    assign htr    = {dmem_htrans[1], imem_htrans[1], spi_htrans[1]};
    assign trd    = {reg_read, data_read, inst_read};
    assign {dmem_hrdata, imem_hrdata, spi_hrdata} = hrdata;
    assign {dmem_hready, imem_hready, spi_hready} = hready;
    assign {dmem_hresp, imem_hresp, spi_hresp}    = hresp;
    assign {inst_en, inst_rwn, inst_wben, inst_addr, inst_write} = {ten[0], trwn[0], twben[0], taddr[0], twrite[0]};
    assign {data_en, data_rwn, data_wben, data_addr, data_write} = {ten[1], trwn[1], twben[1], taddr[1], twrite[1]};
    assign {reg_en, reg_rwn, reg_wben, reg_addr, reg_write} = {ten[2], trwn[2], twben[2], taddr[2][REG_AW-1:0], twrite[2]};
    assign unused = ^{spi_htrans[0], imem_htrans[0], dmem_htrans[0], spi_hburst, imem_hburst, dmem_hburst,
                      spi_hprot, imem_hprot, dmem_hprot, spi_hmastlock, imem_hmastlock, dmem_hmastlock,
                      idle[2:1], taddr[2][RAM_AW-1:REG_AW]};
    // Per-target arbiter: higher-index masters override lower ones, so dmem beats imem
    always_comb begin
        ten = '0;
        sel = '0;
        for (int i = 0; i < 3; i++)
            if (req[i]) begin
                ten[tgt[i]] = 1'b1;
                sel[tgt[i]] = 2'(i);
            end
    end
    for (genvar m = 0; m < 3; m++) begin : g_m
        state_t        st, nst;
        logic [CW-1:0] ca;
        logic [1:0]    cs;
        logic          cw, active, acc, err;
        logic [31:0]   rdq;
        assign active  = (m == 0) || run_mode;
        assign tgt[m]  = ca[RAM_AW+3] ? 2'd2 : {1'b0, ca[RAM_AW+2]};
        assign widx[m] = ca[RAM_AW+1:2];
        assign be[m]   = cs == 2'd0 ? 4'b0001 << ca[1:0] : cs == 2'd1 ? (ca[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        assign cwr[m]  = cw;
        assign req[m]  = reset && (st == WPEND || st == RISSUE);
        assign gnt[m]  = ten[tgt[m]] && sel[tgt[m]] == 2'(m);
        assign idle[m] = st == IDLE;
        assign err = |haddr[m][31:CW] || hsize[m] > 3'd2 || (hsize[m] == 3'd1 && haddr[m][0]) ||
                     (hsize[m] == 3'd2 && |haddr[m][1:0]) ||
                     (m == 1 && (hwrite[m] || |haddr[m][RAM_AW+3:RAM_AW+2])) || (m == 0 && run_mode);
        assign hready[m] = acc;
        assign hresp[m]  = st == ERR1 || st == ERR2;
        assign hrdata[m] = st == RDATA ? trd[tgt[m]] : rdq;
        // Data-phase next state; any cycle completing with hready high may accept the next transfer
        always_comb begin
            acc = active && (st == IDLE || st == RDATA || st == ERR2 || (st == WPEND && gnt[m]));
            nst = st;
            if (acc)
                nst = !htr[m] ? IDLE : err ? ERR1 : hwrite[m] ? WPEND : RISSUE;
            else if (st == RISSUE && gnt[m])
                nst = RDATA;
            else if (st == ERR1)
                nst = ERR2;
        end
        // State, captured address/control and held read data
        always_ff @(posedge clk) begin
            if (!reset) begin
                st  <= IDLE;
                ca  <= '0;
                cs  <= '0;
                cw  <= 1'b0;
                rdq <= '0;
            end else begin
                st <= nst;
                if (acc && htr[m]) begin
                    ca <= haddr[m][CW-1:0];
                    cs <= hsize[m][1:0];
                    cw <= hwrite[m];
                end
                if (st == RDATA)
                    rdq <= trd[tgt[m]];
            end
        end
    end
    for (genvar t = 0; t < 3; t++) begin : g_t
        logic [RAM_AW-1:0] aq;
        logic [31:0]       wq;
        logic              wr;
        assign wr        = ten[t] && cwr[sel[t]];
        assign taddr[t]  = ten[t] ? widx[sel[t]] : aq;
        assign twrite[t] = wr ? hwdata[sel[t]] : wq;
        assign twben[t]  = wr ? be[sel[t]] : 4'b0000;
        assign trwn[t]   = !wr;
        // Idle targets keep presenting the last address and write data
        always_ff @(posedge clk) begin
            if (!reset) begin
                aq <= '0;
                wq <= '0;
            end else begin
                aq <= taddr[t];
                wq <= twrite[t];
            end
        end
    end
    // BOOT->RUN request is remembered until SPI is idle with nothing being captured
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_mode <= !BOOT_ON_RESET;
            chg      <= 1'b0;
        end else begin
            chg <= chg || SPI_change;
            if ((SPI_change || chg) && idle[0] && !htr[0])
                run_mode <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_mem_router.sv
// tb_ahb_mem_router: scoreboard bench for the AHB crossbar with behavioural RAM/register models
module tb_ahb_mem_router;
    logic clk = 0, reset = 0, SPI_change = 0, run_mode;
    logic [31:0] spi_haddr = 0, spi_hwdata = 0, imem_haddr = 0, imem_hwdata = 0, dmem_haddr = 0, dmem_hwdata = 0;
    logic spi_hwrite = 0, imem_hwrite = 0, dmem_hwrite = 0;
    logic [2:0] spi_hsize = 0, imem_hsize = 0, dmem_hsize = 0;
    logic [1:0] spi_htrans = 0, imem_htrans = 0, dmem_htrans = 0;
    logic [2:0] hburst = 0;
    logic [3:0] hprot = 0;
    logic hmastlock = 0;
    logic [31:0] spi_hrdata, imem_hrdata, dmem_hrdata;
    logic spi_hready, imem_hready, dmem_hready, spi_hresp, imem_hresp, dmem_hresp;
    logic [31:0] inst_read = 0, data_read = 0, reg_read = 0, inst_write, data_write, reg_write;
    logic [12:0] inst_addr, data_addr;
    logic [3:0] reg_addr, inst_wben, data_wben, reg_wben;
    logic inst_rwn, data_rwn, reg_rwn, inst_en, data_en, reg_en;
    int n_cmp = 0, n_bad = 0;

    ahb_mem_router dut (
        .clk(clk), .reset(reset), .SPI_change(SPI_change), .run_mode(run_mode),
        .spi_haddr(spi_haddr), .spi_hwdata(spi_hwdata), .spi_hwrite(spi_hwrite), .spi_hsize(spi_hsize),
        .spi_htrans(spi_htrans), .spi_hburst(hburst), .spi_hprot(hprot), .spi_hmastlock(hmastlock),
        .spi_hrdata(spi_hrdata), .spi_hready(spi_hready), .spi_hresp(spi_hresp),
        .imem_haddr(imem_haddr), .imem_hwdata(imem_hwdata), .imem_hwrite(imem_hwrite), .imem_hsize(imem_hsize),
        .imem_htrans(imem_htrans), .imem_hburst(hburst), .imem_hprot(hprot), .imem_hmastlock(hmastlock),
        .imem_hrdata(imem_hrdata), .imem_hready(imem_hready), .imem_hresp(imem_hresp),
        .dmem_haddr(dmem_haddr), .dmem_hwdata(dmem_hwdata), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize),
        .dmem_htrans(dmem_htrans), .dmem_hburst(hburst), .dmem_hprot(hprot), .dmem_hmastlock(hmastlock),
        .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
        .inst_read(inst_read), .inst_write(inst_write), .inst_addr(inst_addr), .inst_wben(inst_wben),
        .inst_rwn(inst_rwn), .inst_en(inst_en),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wben(data_wben),
        .data_rwn(data_rwn), .data_en(data_en),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr), .reg_wben(reg_wben),
        .reg_rwn(reg_rwn), .reg_en(reg_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Memory models: one-cycle read latency, byte-enabled writes, patterned initial contents
    logic [31:0] im [8192];
    logic [31:0] dm [8192];
    logic [31:0] rm [16];
    logic init_done = 0;
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 8192; i++) begin
                im[i] <= 32'h1000_0000 + i;
                dm[i] <= 32'h5000_0000 + i;
            end
            for (int i = 0; i < 16; i++) rm[i] <= 32'h7000_0000 + i;
            init_done <= 1;
        end
        if (inst_en === 1'b1) begin
            if (inst_rwn) inst_read <= im[inst_addr]; else im[inst_addr] <= merge(im[inst_addr], inst_write, inst_wben);
        end
        if (data_en === 1'b1) begin
            if (data_rwn) data_read <= dm[data_addr]; else dm[data_addr] <= merge(dm[data_addr], data_write, data_wben);
        end
        if (reg_en === 1'b1) begin
            if (reg_rwn) reg_read <= rm[reg_addr]; else rm[reg_addr] <= merge(rm[reg_addr], reg_write, reg_wben);
        end
    end

    typedef struct packed {logic [1:0] tg; logic rwn; logic [3:0] be; logic [15:0] addr; logic [31:0] wd;} strobe_t;
    strobe_t sq[$];
    strobe_t mon_e;

    task automatic exp_strobe(input logic [1:0] tg, input logic rwn, input logic [3:0] b, input logic [15:0] a, input logic [31:0] d);
        strobe_t s;
        s.tg = tg; s.rwn = rwn; s.be = b; s.addr = a; s.wd = d;
        sq.push_back(s);
    endtask

    function automatic logic s_en(input int t);
        return t == 0 ? inst_en : t == 1 ? data_en : reg_en;
    endfunction
    function automatic logic s_rwn(input int t);
        return t == 0 ? inst_rwn : t == 1 ? data_rwn : reg_rwn;
    endfunction
    function automatic logic [3:0] s_wben(input int t);
        return t == 0 ? inst_wben : t == 1 ? data_wben : reg_wben;
    endfunction
    function automatic logic [15:0] s_addr(input int t);
        return t == 0 ? {3'b0, inst_addr} : t == 1 ? {3'b0, data_addr} : {12'b0, reg_addr};
    endfunction
    function automatic logic [31:0] s_wr(input int t);
        return t == 0 ? inst_write : t == 1 ? data_write : reg_write;
    endfunction

    // Scoreboard pop: every target strobe must match the next expected one
    always @(negedge clk) begin
        for (int t = 0; t < 3; t++) begin
            if (s_en(t) === 1'b1) begin
                if (sq.size() == 0) chk("strobe_unexpected", 32'(sq.size()), 32'd1);
                else begin
                    mon_e = sq.pop_front();
                    chk("strobe_tgt", 32'(t), 32'(mon_e.tg));
                    chk("strobe_rwn", 32'(s_rwn(t)), 32'(mon_e.rwn));
                    chk("strobe_wben", 32'(s_wben(t)), 32'(mon_e.be));
                    chk("strobe_addr", 32'(s_addr(t)), 32'(mon_e.addr));
                    if (!mon_e.rwn) chk("strobe_wdata", s_wr(t), mon_e.wd);
                end
            end
        end
    end

    task automatic drive(input int m, input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
        case (m)
            0: begin spi_haddr = a; spi_hwrite = w; spi_hsize = sz; spi_htrans = tr; end
            1: begin imem_haddr = a; imem_hwrite = w; imem_hsize = sz; imem_htrans = tr; end
            default: begin dmem_haddr = a; dmem_hwrite = w; dmem_hsize = sz; dmem_htrans = tr; end
        endcase
    endtask
    task automatic wdata(input int m, input logic [31:0] d);
        case (m)
            0: spi_hwdata = d;
            1: imem_hwdata = d;
            default: dmem_hwdata = d;
        endcase
    endtask
    function automatic logic hrdy(input int m);
        return m == 0 ? spi_hready : m == 1 ? imem_hready : dmem_hready;
    endfunction
    function automatic logic hrsp(input int m);
        return m == 0 ? spi_hresp : m == 1 ? imem_hresp : dmem_hresp;
    endfunction
    function automatic logic [31:0] hrd(input int m);
        return m == 0 ? spi_hrdata : m == 1 ? imem_hrdata : dmem_hrdata;
    endfunction

    // One single transfer: address phase, then wait (bounded) for hready in the data phase
    task automatic xfer(input int m, input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] d,
                        input int exp_lat, input logic exp_resp, input logic [31:0] exp_rd, input string tag);
        int lat;
        logic done;
        lat = 0;
        done = 0;
        @(posedge clk); #1;
        drive(m, a, w, sz, 2'b10);
        @(posedge clk); #1;
        drive(m, 32'h0, 1'b0, 3'd0, 2'b00);
        wdata(m, d);
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            done = hrdy(m);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_resp"}, 32'(hrsp(m)), 32'(exp_resp));
        if (!w && !exp_resp) chk({tag, "_rdata"}, hrd(m), exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_run_mode", 32'(run_mode), 32'd0);
        chk("rst_spi_hready", 32'(spi_hready), 32'd1);
        chk("rst_imem_hready", 32'(imem_hready), 32'd0);
        chk("rst_dmem_hready", 32'(dmem_hready), 32'd0);
        chk("rst_spi_hresp", 32'(spi_hresp), 32'd0);
        chk("rst_spi_hrdata", spi_hrdata, 32'd0);
        chk("rst_inst_en", 32'(inst_en), 32'd0);
        chk("rst_inst_rwn", 32'(inst_rwn), 32'd1);
        chk("rst_data_wben", 32'(data_wben), 32'd0);
        chk("rst_inst_addr", 32'(inst_addr), 32'd0);
        chk("rst_reg_write", reg_write, 32'd0);
        @(posedge clk); #1;
        reset = 1;
        // BOOT: SPI word writes to both RAMs
        exp_strobe(2'd0, 1'b0, 4'hF, 16'd4, 32'hDEADBEEF);
        xfer(0, 32'h0000_0010, 1'b1, 3'd2, 32'hDEADBEEF, 1, 1'b0, 32'h0, "spi_wr_i");
        chk("imem_hready_boot", 32'(imem_hready), 32'd0);
        exp_strobe(2'd1, 1'b0, 4'hF, 16'd4, 32'hDEADBEEF);
        xfer(0, 32'h0000_8010, 1'b1, 3'd2, 32'hDEADBEEF, 1, 1'b0, 32'h0, "spi_wr_d");
        chk("dmem_hready_boot", 32'(dmem_hready), 32'd0);
        // Byte lane write, misaligned halfword, readback
        exp_strobe(2'd1, 1'b0, 4'b1000, 16'd0, 32'hAA00_0000);
        xfer(0, 32'h0000_8003, 1'b1, 3'd0, 32'hAA00_0000, 1, 1'b0, 32'h0, "spi_wr_b");
        xfer(0, 32'h0000_8001, 1'b1, 3'd1, 32'h0000_5555, 2, 1'b1, 32'h0, "spi_half_mis");
        exp_strobe(2'd1, 1'b1, 4'b0000, 16'd0, 32'h0);
        xfer(0, 32'h0000_8000, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'hAA00_0000, "spi_rd_b");
        // Mode change requested during a read data phase
        exp_strobe(2'd0, 1'b1, 4'b0000, 16'd4, 32'h0);
        fork
            xfer(0, 32'h0000_0010, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'hDEADBEEF, "spi_rd_chg");
            begin
                @(posedge clk);
                @(posedge clk); #1;
                SPI_change = 1;
                @(posedge clk); #1;
                SPI_change = 0;
            end
        join
        chk("run_mode_in_rdata", 32'(run_mode), 32'd0);
        @(negedge clk);
        chk("run_mode_idle", 32'(run_mode), 32'd0);
        @(negedge clk);
        chk("run_mode_set", 32'(run_mode), 32'd1);
        chk("imem_hready_run", 32'(imem_hready), 32'd1);
        xfer(0, 32'h0000_0010, 1'b1, 3'd2, 32'h1111_1111, 2, 1'b1, 32'h0, "spi_run_err");
        // RUN: contention on the instruction RAM, dmem wins
        exp_strobe(2'd0, 1'b1, 4'b0000, 16'd9, 32'h0);
        exp_strobe(2'd0, 1'b1, 4'b0000, 16'd8, 32'h0);
        fork
            xfer(1, 32'h0000_0020, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h1000_0008, "imem_rd_lose");
            xfer(2, 32'h0000_0024, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'h1000_0009, "dmem_rd_win");
        join
        exp_strobe(2'd0, 1'b1, 4'b0000, 16'd4, 32'h0);
        xfer(1, 32'h0000_0010, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'hDEADBEEF, "imem_rd");
        xfer(1, 32'h0000_0020, 1'b1, 3'd2, 32'h0BAD_0BAD, 2, 1'b1, 32'h0, "imem_wr_err");
        xfer(1, 32'h0001_0000, 1'b0, 3'd2, 32'h0, 2, 1'b1, 32'h0, "imem_reg_err");
        exp_strobe(2'd2, 1'b1, 4'b0000, 16'd3, 32'h0);
        xfer(2, 32'h0001_000C, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'h7000_0003, "dmem_rd_reg");
        exp_strobe(2'd2, 1'b0, 4'b1100, 16'd5, 32'h1234_0000);
        xfer(2, 32'h0001_0016, 1'b1, 3'd1, 32'h1234_0000, 1, 1'b0, 32'h0, "dmem_wr_half");
        exp_strobe(2'd2, 1'b1, 4'b0000, 16'd5, 32'h0);
        xfer(2, 32'h0001_0014, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'h1234_0005, "dmem_rd_half");
        xfer(2, 32'h0002_0000, 1'b0, 3'd2, 32'h0, 2, 1'b1, 32'h0, "dmem_hi_err");
        xfer(2, 32'h0000_8000, 1'b0, 3'd3, 32'h0, 2, 1'b1, 32'h0, "dmem_size_err");
        // Reset during a pending write data phase
        @(posedge clk); #1;
        drive(2, 32'h0000_8020, 1'b1, 3'd2, 2'b10);
        @(posedge clk); #1;
        drive(2, 32'h0, 1'b0, 3'd0, 2'b00);
        dmem_hwdata = 32'hCAFE_F00D;
        reset = 0;
        @(negedge clk);
        chk("rst_mid_data_en", 32'(data_en), 32'd0);
        @(negedge clk);
        chk("rst2_run_mode", 32'(run_mode), 32'd0);
        chk("rst2_imem_hready", 32'(imem_hready), 32'd0);
        chk("rst2_spi_hready", 32'(spi_hready), 32'd1);
        chk("rst2_data_rwn", 32'(data_rwn), 32'd1);
        chk("rst2_data_addr", 32'(data_addr), 32'd0);
        chk("rst2_data_write", data_write, 32'd0);
        chk("rst2_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst2_dmem_hrdata", dmem_hrdata, 32'd0);
        chk("rst2_no_write", dm[8], 32'h5000_0008);
        @(posedge clk); #1;
        reset = 1;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
